// File: rtl/fmc_bus_master.sv
// FMC multiplexed address/data bus initiator (NOR/PSRAM muxed mode, no NWAIT).
// Runs one read or write per accepted command. The phase lengths come from the
// ADDSET/ADDHLD/DATAST/BUSTURN parameters. Every pin-facing strobe and the
// bus-enable come straight from a flop, so the pins never glitch.
module fmc_bus_master #(
   parameter int ADDSET  = 2,   // NADV low, address on bus (>= 1)
   parameter int ADDHLD  = 1,   // address hold after NADV rises (>= 1)
   parameter int DATAST  = 4,   // NOE/NWE low (>= 1)
   parameter int BUSTURN = 2    // all strobes high before idle (>= 1)
) (
   input  logic        sys_clk,
   input  logic        sys_rst_n,
   input  logic        cmd_valid,
   output logic        cmd_ready,
   input  logic        cmd_wr,
   input  logic [15:0] cmd_addr,
   input  logic [15:0] cmd_wdata,
   output logic        rsp_valid,
   output logic [15:0] rsp_rdata,
   output logic        busy,
   output logic        fpga_nl_nadv,
   output logic        fpga_cs_ne1,
   output logic        fpga_wr_nwe,
   output logic        fpga_rd_noe,
   inout  wire  [15:0] fpga_db
);

   localparam int CNT_W = 8;

   typedef enum logic [2:0] {
      S_IDLE,
      S_ADDR,
      S_AHOLD,
      S_DATA,
      S_TURN
   } state_t;

   state_t            state_q, state_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic              wr_q, wr_d;
   logic [15:0]       addr_q, addr_d;
   logic [15:0]       wdata_q, wdata_d;
   logic              ne1_q, ne1_d;
   logic              nadv_q, nadv_d;
   logic              nwe_q, nwe_d;
   logic              noe_q, noe_d;
   logic              oe_q, oe_d;
   logic [15:0]       db_q, db_d;
   logic              rsp_valid_q, rsp_valid_d;
   logic [15:0]       rdata_q, rdata_d;
   logic              busy_q, busy_d;
   logic              accept;
   logic              cnt_done;

   assign cmd_ready = (state_q == S_IDLE);
   assign accept    = cmd_valid & cmd_ready;
   assign cnt_done  = (cnt_q == '0);

   // Next state, phase counter, command latch and the next value of every registered output
   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_done ? '0 : cnt_q - CNT_W'(1);
      wr_d        = wr_q;
      addr_d      = addr_q;
      wdata_d     = wdata_q;
      rdata_d     = rdata_q;
      rsp_valid_d = 1'b0;

      case (state_q)
         S_IDLE: begin
            if (accept) begin
               state_d = S_ADDR;
               cnt_d   = CNT_W'(ADDSET - 1);
               wr_d    = cmd_wr;
               addr_d  = cmd_addr;
               wdata_d = cmd_wdata;
            end
         end
         S_ADDR: begin
            if (cnt_done) begin
               state_d = S_AHOLD;
               cnt_d   = CNT_W'(ADDHLD - 1);
            end
         end
         S_AHOLD: begin
            if (cnt_done) begin
               state_d = S_DATA;
               cnt_d   = CNT_W'(DATAST - 1);
            end
         end
         S_DATA: begin
            if (cnt_done) begin
               // This edge also raises NOE. The responder shares our clock, so the
               // bus is still valid here and is sampled with no resynchronisation.
               state_d     = S_TURN;
               cnt_d       = CNT_W'(BUSTURN - 1);
               rsp_valid_d = 1'b1;
               if (!wr_q) rdata_d = fpga_db;
            end
         end
         S_TURN: begin
            if (cnt_done) state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
            cnt_d   = '0;
         end
      endcase

      // The strobes follow the state being entered, so they switch together with it.
      ne1_d  = !((state_d == S_ADDR) || (state_d == S_AHOLD) || (state_d == S_DATA));
      nadv_d = !(state_d == S_ADDR);
      nwe_d  = !((state_d == S_DATA) && wr_d);
      noe_d  = !((state_d == S_DATA) && !wr_d);
      busy_d = (state_d != S_IDLE);

      // Address drive during ADDR/AHOLD. A write keeps its data on the bus for
      // one cycle after NWE rises. A read never drives the bus while NOE is low.
      case (state_d)
         S_ADDR, S_AHOLD: oe_d = 1'b1;
         S_DATA:          oe_d = wr_d;
         S_TURN:          oe_d = wr_d && (state_q == S_DATA);
         default:         oe_d = 1'b0;
      endcase
      db_d = ((state_d == S_ADDR) || (state_d == S_AHOLD)) ? addr_d : wdata_d;
   end

   // State, counter, command latch and output registers. The synchronous reset
   // forces every strobe high in one edge, from any phase of a transaction.
   always_ff @(posedge sys_clk) begin
      if (!sys_rst_n) begin
         state_q     <= S_IDLE;
         cnt_q       <= '0;
         wr_q        <= 1'b0;
         addr_q      <= '0;
         wdata_q     <= '0;
         ne1_q       <= 1'b1;
         nadv_q      <= 1'b1;
         nwe_q       <= 1'b1;
         noe_q       <= 1'b1;
         oe_q        <= 1'b0;
         db_q        <= '0;
         rsp_valid_q <= 1'b0;
         rdata_q     <= '0;
         busy_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         wr_q        <= wr_d;
         addr_q      <= addr_d;
         wdata_q     <= wdata_d;
         ne1_q       <= ne1_d;
         nadv_q      <= nadv_d;
         nwe_q       <= nwe_d;
         noe_q       <= noe_d;
         oe_q        <= oe_d;
         db_q        <= db_d;
         rsp_valid_q <= rsp_valid_d;
         rdata_q     <= rdata_d;
         busy_q      <= busy_d;
      end
   end

   assign fpga_cs_ne1  = ne1_q;
   assign fpga_nl_nadv = nadv_q;
   assign fpga_wr_nwe  = nwe_q;
   assign fpga_rd_noe  = noe_q;
   assign fpga_db      = oe_q ? db_q : 16'hzzzz;
   assign rsp_valid    = rsp_valid_q;
   assign rsp_rdata    = rdata_q;
   assign busy         = busy_q;

endmodule

// File: tb/tb_fmc_bus_master.sv
// Directed bench for fmc_bus_master. It uses two instances: one with default
// timing and one with minimum timing. Each has a pulled-up bus and a responder
// that drives read data while NOE is low. An undriven bus therefore reads as all ones.
module tb_fmc_bus_master;

   localparam logic [15:0] BUS_Z  = 16'hFFFF;
   // {ne1, nadv, nwe, noe, busy, rsp_valid, cmd_ready}
   localparam logic [6:0]  IDLE_C = 7'b1111_001;
   localparam logic [6:0]  ADDR_C = 7'b0011_100;
   localparam logic [6:0]  AHLD_C = 7'b0111_100;
   localparam logic [6:0]  DWR_C  = 7'b0101_100;
   localparam logic [6:0]  DRD_C  = 7'b0110_100;
   localparam logic [6:0]  TRN1_C = 7'b1111_110;
   localparam logic [6:0]  TRN2_C = 7'b1111_100;

   logic clk = 1'b0;
   logic rst_n;
   int   checks = 0;
   int   errors = 0;

   // default-timing instance
   logic        cmd_valid, cmd_wr, cmd_ready, rsp_valid, busy;
   logic [15:0] cmd_addr, cmd_wdata, rsp_rdata, resp_val;
   logic        nadv, ne1, nwe, noe;
   wire  [15:0] db;
   // minimum-timing instance
   logic        cmd_valid_m, cmd_wr_m, cmd_ready_m, rsp_valid_m, busy_m;
   logic [15:0] cmd_addr_m, cmd_wdata_m, rsp_rdata_m, resp_val_m;
   logic        nadv_m, ne1_m, nwe_m, noe_m;
   wire  [15:0] db_m;

   always #5 clk = ~clk;

   for (genvar i = 0; i < 16; i++) begin : g_pu
      pullup (db[i]);
      pullup (db_m[i]);
   end
   assign db   = !noe   ? resp_val   : 16'hzzzz;
   assign db_m = !noe_m ? resp_val_m : 16'hzzzz;

   fmc_bus_master u_dut (
      .sys_clk(clk), .sys_rst_n(rst_n),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_wr(cmd_wr),
      .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
      .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .busy(busy),
      .fpga_nl_nadv(nadv), .fpga_cs_ne1(ne1), .fpga_wr_nwe(nwe),
      .fpga_rd_noe(noe), .fpga_db(db)
   );

   fmc_bus_master #(.ADDSET(1), .ADDHLD(1), .DATAST(1), .BUSTURN(1)) u_min (
      .sys_clk(clk), .sys_rst_n(rst_n),
      .cmd_valid(cmd_valid_m), .cmd_ready(cmd_ready_m), .cmd_wr(cmd_wr_m),
      .cmd_addr(cmd_addr_m), .cmd_wdata(cmd_wdata_m),
      .rsp_valid(rsp_valid_m), .rsp_rdata(rsp_rdata_m), .busy(busy_m),
      .fpga_nl_nadv(nadv_m), .fpga_cs_ne1(ne1_m), .fpga_wr_nwe(nwe_m),
      .fpga_rd_noe(noe_m), .fpga_db(db_m)
   );

   wire [6:0] ctl   = {ne1, nadv, nwe, noe, busy, rsp_valid, cmd_ready};
   wire [6:0] ctl_m = {ne1_m, nadv_m, nwe_m, noe_m, busy_m, rsp_valid_m, cmd_ready_m};

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Expected strobes and bus for cycle i after accept (default timing: 2/1/4/2).
   task automatic chk_def(input string tag, input int i, input logic wr,
                          input logic [15:0] a, input logic [15:0] d, input logic [15:0] rd);
      logic [6:0]  c;
      logic [15:0] b;
      if (i < 2)       begin c = ADDR_C; b = a; end
      else if (i == 2) begin c = AHLD_C; b = a; end
      else if (i < 7)  begin c = wr ? DWR_C : DRD_C; b = wr ? d : rd; end
      else if (i == 7) begin c = TRN1_C; b = wr ? d : BUS_Z; end
      else if (i == 8) begin c = TRN2_C; b = BUS_Z; end
      else             begin c = IDLE_C; b = BUS_Z; end
      chk($sformatf("%s.ctl[%0d]", tag, i), {9'd0, ctl}, {9'd0, c});
      chk($sformatf("%s.db[%0d]", tag, i), db, b);
   endtask

   // Minimum timing: ADDR, AHOLD, DATA and TURN each last one cycle.
   task automatic chk_min(input string tag, input int i, input logic wr,
                          input logic [15:0] a, input logic [15:0] d, input logic [15:0] rd);
      logic [6:0]  c;
      logic [15:0] b;
      if (i == 0)      begin c = ADDR_C; b = a; end
      else if (i == 1) begin c = AHLD_C; b = a; end
      else if (i == 2) begin c = wr ? DWR_C : DRD_C; b = wr ? d : rd; end
      else if (i == 3) begin c = TRN1_C; b = wr ? d : BUS_Z; end
      else             begin c = IDLE_C; b = BUS_Z; end
      chk($sformatf("%s.ctl[%0d]", tag, i), {9'd0, ctl_m}, {9'd0, c});
      chk($sformatf("%s.db[%0d]", tag, i), db_m, b);
   endtask

   initial begin
      int rdy_low;
      rst_n = 1'b0;
      cmd_valid = 0; cmd_wr = 0; cmd_addr = 0; cmd_wdata = 0; resp_val = 16'h0000;
      cmd_valid_m = 0; cmd_wr_m = 0; cmd_addr_m = 0; cmd_wdata_m = 0; resp_val_m = 16'h0000;
      repeat (3) tick();

      // reset state
      chk("rst.ctl", {9'd0, ctl}, {9'd0, IDLE_C});
      chk("rst.db", db, BUS_Z);
      chk("rst.rdata", rsp_rdata, 16'h0000);
      chk("rst.ctl_m", {9'd0, ctl_m}, {9'd0, IDLE_C});
      rst_n = 1'b1;
      tick();

      // 1: write 0x0003 <- 0xA5A5. After accept, the command fields are scrambled
      // and cmd_valid toggles while busy; neither may disturb the transfer.
      cmd_valid = 1; cmd_wr = 1; cmd_addr = 16'h0003; cmd_wdata = 16'hA5A5;
      tick();
      cmd_wr = 0; cmd_addr = 16'h7777; cmd_wdata = 16'h0000;
      for (int i = 0; i < 11; i++) begin
         chk_def("wr1", i, 1'b1, 16'h0003, 16'hA5A5, 16'h0000);
         cmd_valid = (i < 8) ? i[0] : 1'b0;
         tick();
      end

      // 2: read 0x0001, responder returns 0x1234
      resp_val = 16'h1234;
      cmd_valid = 1; cmd_wr = 0; cmd_addr = 16'h0001;
      tick();
      cmd_valid = 0;
      for (int i = 0; i < 10; i++) begin
         chk_def("rd1", i, 1'b0, 16'h0001, 16'h0000, 16'h1234);
         if (i == 7) chk("rd1.rdata", rsp_rdata, 16'h1234);
         tick();
      end
      // the next write must leave rsp_rdata untouched
      cmd_valid = 1; cmd_wr = 1; cmd_addr = 16'h0005; cmd_wdata = 16'h0C0C;
      tick();
      cmd_valid = 0;
      for (int i = 0; i < 10; i++) begin
         chk_def("wr2", i, 1'b1, 16'h0005, 16'h0C0C, 16'h0000);
         if (i == 7) chk("wr2.rdata_kept", rsp_rdata, 16'h1234);
         tick();
      end

      // 3: back-to-back with cmd_valid held: write 0x0002/0xBEEF, then read 0x0002
      resp_val = 16'h5678;
      cmd_valid = 1; cmd_wr = 1; cmd_addr = 16'h0002; cmd_wdata = 16'hBEEF;
      tick();
      cmd_wr = 0; cmd_wdata = 16'hDEAD;
      rdy_low = 0;
      for (int i = 0; i < 20; i++) begin
         if (i < 10) chk_def("b2b.wr", i, 1'b1, 16'h0002, 16'hBEEF, 16'h0000);
         else        chk_def("b2b.rd", i - 10, 1'b0, 16'h0002, 16'h0000, 16'h5678);
         if (i == 7)  chk("b2b.rdata_kept", rsp_rdata, 16'h1234);
         if (i == 17) chk("b2b.rdata", rsp_rdata, 16'h5678);
         if (i < 10 && !cmd_ready) rdy_low++;
         if (i == 10) cmd_valid = 0;
         tick();
      end
      chk("b2b.rdy_low_cycles", 16'(rdy_low), 16'd9);

      // 4: reset on the second DATA cycle of a write, then a normal read
      cmd_valid = 1; cmd_wr = 1; cmd_addr = 16'h0004; cmd_wdata = 16'h1111;
      tick();
      cmd_valid = 0;
      for (int i = 0; i < 5; i++) begin
         chk_def("rstmid", i, 1'b1, 16'h0004, 16'h1111, 16'h0000);
         if (i == 4) rst_n = 1'b0;
         tick();
      end
      chk("rstmid.ctl", {9'd0, ctl}, {9'd0, IDLE_C});
      chk("rstmid.db", db, BUS_Z);
      chk("rstmid.rdata", rsp_rdata, 16'h0000);
      rst_n = 1'b1;
      tick();
      chk("rstmid.ctl2", {9'd0, ctl}, {9'd0, IDLE_C});
      resp_val = 16'h0F0F;
      cmd_valid = 1; cmd_wr = 0; cmd_addr = 16'h0001;
      tick();
      cmd_valid = 0;
      for (int i = 0; i < 10; i++) begin
         chk_def("rd2", i, 1'b0, 16'h0001, 16'h0000, 16'h0F0F);
         if (i == 7) chk("rd2.rdata", rsp_rdata, 16'h0F0F);
         tick();
      end

      // 5: minimum timing, read then write
      resp_val_m = 16'hC3C3;
      cmd_valid_m = 1; cmd_wr_m = 0; cmd_addr_m = 16'h00AA;
      tick();
      cmd_valid_m = 0;
      for (int i = 0; i < 5; i++) begin
         chk_min("min.rd", i, 1'b0, 16'h00AA, 16'h0000, 16'hC3C3);
         if (i == 3) chk("min.rdata", rsp_rdata_m, 16'hC3C3);
         tick();
      end
      cmd_valid_m = 1; cmd_wr_m = 1; cmd_addr_m = 16'h0055; cmd_wdata_m = 16'h3C3C;
      tick();
      cmd_valid_m = 0;
      for (int i = 0; i < 5; i++) begin
         chk_min("min.wr", i, 1'b1, 16'h0055, 16'h3C3C, 16'h0000);
         if (i == 3) chk("min.rdata_kept", rsp_rdata_m, 16'hC3C3);
         tick();
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
